// File: rtl/microprocessor.sv
// Single-cycle RV32I-subset core (ADDI, ADD, BEQ, JAL) for the Fibonacci demo.
// PC register, opcode-only decode, immediate generation, 32x32 register file
// with two combinational read ports, and a single adder ALU.
// Optional macro IMEM_EN: fetch from an internal ROM (IMEM_DEPTH words, taken
// from IMEM_INIT at elaboration) instead of the instruction port.
module microprocessor #(
  parameter int DATA_WIDTH = 32,
  parameter int DIR_WIDTH  = 5,
  parameter int IMEM_DEPTH = 64,
  parameter logic [IMEM_DEPTH-1:0][DATA_WIDTH-1:0] IMEM_INIT = '0
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rf_we,
  output logic [DIR_WIDTH-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREGS = 1 << DIR_WIDTH;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] rf_q [NREGS];
  logic [DATA_WIDTH-1:0] rf_d [NREGS];
  logic [DATA_WIDTH-1:0] inst;

`ifdef IMEM_EN
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  // Upper PC bits are dropped so addresses past the ROM alias by index.
  assign inst = IMEM_INIT[pc_q[IMEM_AW+1:2]];
  logic unused_instruction;
  assign unused_instruction = ^instruction;
`else
  assign inst = instruction;
`endif

  logic [6:0]            opcode;
  logic [DIR_WIDTH-1:0]  rs1, rs2, rd;
  logic [DATA_WIDTH-1:0] rs1_data, rs2_data;
  logic [DATA_WIDTH-1:0] imm_i, imm_b, imm_j;
  logic [DATA_WIDTH-1:0] op1, op2, alu, pc_plus4;
  logic                  we_dec;
  logic                  unused_funct3;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign unused_funct3 = ^inst[14:12];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // x0 is hard-wired to zero on both read ports.
  assign rs1_data = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_data = (rs2 == '0) ? '0 : rf_q[rs2];
  assign pc_plus4 = pc_q + 32'd4;

  // Decode: pick ALU operands, write enable and next PC from the opcode.
  always_comb begin
    op1    = rs1_data;
    op2    = rs2_data;
    we_dec = 1'b0;
    pc_d   = pc_plus4;
    case (opcode)
      OP_ADDI: begin op2 = imm_i; we_dec = 1'b1; end
      OP_ADD:  we_dec = 1'b1;
      OP_BEQ:  op2 = -rs2_data;
      OP_JAL: begin
        op1    = pc_q;
        op2    = 32'd4;
        we_dec = 1'b1;
        pc_d   = (pc_q + imm_j) & ~32'd3;
      end
      default: ;
    endcase
    alu = op1 + op2;
    // BEQ reuses the adder as a subtractor; zero difference means equal.
    if (opcode == OP_BEQ && alu == '0) pc_d = (pc_q + imm_b) & ~32'd3;
  end

  assign alu_result = alu;
  assign rf_wdata   = alu;
  assign rf_waddr   = rd;
  assign rf_we      = we_dec && (rd != '0) && !arst;
  assign pc_out     = pc_q;

  // Next register-file contents: old state plus this cycle's write.
  always_comb begin
    rf_d = rf_q;
    if (rf_we) rf_d[rd] = alu;
  end

  // PC and register file update together; reset clears both immediately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end

endmodule

// File: tb/tb_microprocessor.sv
// Directed bench for the single-cycle core; registers are observed through
// ADDI x0,xN,0 whose alu_result equals xN without writing anything.
module tb_microprocessor;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] instruction = 32'h0000_0013;
  logic [31:0] pc_out, alu_result, rf_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  microprocessor dut (
    .clk(clk), .arst(arst), .instruction(instruction), .pc_out(pc_out),
    .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    logic [11:0] i; logic [4:0] d, s;
    i = imm[11:0]; d = rd[4:0]; s = rs1[4:0];
    return {i, s, 3'b000, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    logic [4:0] d, s1, s2;
    d = rd[4:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_beq(input int rs1, input int rs2, input int imm);
    logic [12:0] b; logic [4:0] s1, s2;
    b = imm[12:0]; s1 = rs1[4:0]; s2 = rs2[4:0];
    return {b[12], b[10:5], s2, s1, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int rd, input int imm);
    logic [20:0] j; logic [4:0] d;
    j = imm[20:0]; d = rd[4:0];
    return {j[20], j[10:1], j[11], j[19:12], d, 7'b1101111};
  endfunction

  task automatic drive(input logic [31:0] i);
    instruction = i; #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic rd_reg(input int r, output logic [31:0] v);
    drive(enc_addi(0, r, 0)); v = alu_result; tick();
  endtask

  task automatic pulse_reset;
    arst = 1'b1; #1; arst = 1'b0; #1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    #2;
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want %h", pc_out, 32'h0); end
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", rf_we); end
    arst = 1'b0;
    drive(NOP); tick();
    tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL nop_pc4: got %h want %h", pc_out, 32'h4); end
    tick();
    tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL nop_pc8: got %h want %h", pc_out, 32'h8); end
    drive(enc_addi(1, 0, 9)); tick();
    // Reset mid-instruction: write of x2 must be dropped, PC back to 0.
    drive(enc_addi(2, 0, 3));
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL pre_rst_we: got %b want 1", rf_we); end
    arst = 1'b1; #1;
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL mid_rst_we: got %b want 0", rf_we); end
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL mid_rst_pc: got %h want %h", pc_out, 32'h0); end
    @(posedge clk); #1; arst = 1'b0;
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL post_rst_pc: got %h want %h", pc_out, 32'h0); end
    for (int r = 1; r < 32; r++) begin
      rd_reg(r, v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_x%0d: got %h want %h", r, v, 32'h0); end
    end
    tests++; if (pc_out !== 32'h7c) begin fails++; $display("FAIL rst_read_pc: got %h want %h", pc_out, 32'h7c); end
  endtask

  task automatic test_addi;
    logic [31:0] v;
    pulse_reset();
    drive(32'h0050_0093);
    tests++; if (alu_result !== 32'd5) begin fails++; $display("FAIL addi_alu: got %h want %h", alu_result, 32'd5); end
    tests++; if (rf_waddr !== 5'd1) begin fails++; $display("FAIL addi_waddr: got %h want %h", rf_waddr, 5'd1); end
    tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL addi_we: got %b want 1", rf_we); end
    tests++; if (rf_wdata !== 32'd5) begin fails++; $display("FAIL addi_wdata: got %h want %h", rf_wdata, 32'd5); end
    tick();
    tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL addi_pc: got %h want %h", pc_out, 32'h4); end
    rd_reg(1, v);
    tests++; if (v !== 32'd5) begin fails++; $display("FAIL addi_x1: got %h want %h", v, 32'd5); end
    drive(32'hFFF0_0113);
    tests++; if (alu_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL addi_neg_alu: got %h want %h", alu_result, 32'hFFFF_FFFF); end
    tick();
    rd_reg(2, v);
    tests++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL addi_x2: got %h want %h", v, 32'hFFFF_FFFF); end
  endtask

  task automatic test_add;
    logic [31:0] v;
    drive(enc_addi(2, 0, 8)); tick();
    drive(32'h0020_81B3);
    tests++; if (alu_result !== 32'd13) begin fails++; $display("FAIL add_alu: got %h want %h", alu_result, 32'd13); end
    tests++; if (rf_waddr !== 5'd3) begin fails++; $display("FAIL add_waddr: got %h want %h", rf_waddr, 5'd3); end
    tick();
    rd_reg(3, v);
    tests++; if (v !== 32'd13) begin fails++; $display("FAIL add_x3: got %h want %h", v, 32'd13); end
    tests++; if (pc_out !== 32'h1c) begin fails++; $display("FAIL add_pc: got %h want %h", pc_out, 32'h1c); end
  endtask

  task automatic test_branch_jump;
    logic [31:0] v;
    pulse_reset();
    drive(enc_addi(1, 0, 5)); tick();
    drive(enc_addi(2, 0, 8)); tick();
    drive(NOP); tick(); tick();
    drive(enc_beq(1, 1, 8));
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL beq_t_we: got %b want 0", rf_we); end
    tests++; if (alu_result !== 32'h0) begin fails++; $display("FAIL beq_t_alu: got %h want %h", alu_result, 32'h0); end
    tick();
    tests++; if (pc_out !== 32'h18) begin fails++; $display("FAIL beq_t_pc: got %h want %h", pc_out, 32'h18); end
    drive(enc_jal(0, -8));
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL jal_x0_we: got %b want 0", rf_we); end
    tests++; if (alu_result !== 32'h1c) begin fails++; $display("FAIL jal_x0_alu: got %h want %h", alu_result, 32'h1c); end
    tick();
    tests++; if (pc_out !== 32'h10) begin fails++; $display("FAIL jal_x0_pc: got %h want %h", pc_out, 32'h10); end
    drive(enc_beq(1, 2, 8));
    tests++; if (alu_result !== 32'hFFFF_FFFD) begin fails++; $display("FAIL beq_nt_alu: got %h want %h", alu_result, 32'hFFFF_FFFD); end
    tick();
    tests++; if (pc_out !== 32'h14) begin fails++; $display("FAIL beq_nt_pc: got %h want %h", pc_out, 32'h14); end
    drive(NOP); tick(); tick(); tick();
    drive(enc_jal(5, -16));
    tests++; if (alu_result !== 32'h24 || rf_we !== 1'b1 || rf_waddr !== 5'd5) begin
      fails++; $display("FAIL jal_x5_wr: got alu=%h we=%b wa=%0d want alu=24 we=1 wa=5", alu_result, rf_we, rf_waddr); end
    tick();
    tests++; if (pc_out !== 32'h10) begin fails++; $display("FAIL jal_x5_pc: got %h want %h", pc_out, 32'h10); end
    rd_reg(5, v);
    tests++; if (v !== 32'h24) begin fails++; $display("FAIL jal_x5_val: got %h want %h", v, 32'h24); end
  endtask

  task automatic test_x0;
    logic [31:0] v;
    drive(enc_addi(0, 0, 7));
    tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL x0_we: got %b want 0", rf_we); end
    tests++; if (alu_result !== 32'd7) begin fails++; $display("FAIL x0_alu: got %h want %h", alu_result, 32'd7); end
    tick();
    rd_reg(0, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL x0_val: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_pc_wrap;
    pulse_reset();
    drive(enc_jal(0, -4)); tick();
    tests++; if (pc_out !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_neg_pc: got %h want %h", pc_out, 32'hFFFF_FFFC); end
    drive(NOP); tick();
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL wrap_pc: got %h want %h", pc_out, 32'h0); end
    // Halfword target: low bits are cleared, so +6 lands on 4.
    drive(enc_jal(0, 6)); tick();
    tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL align_pc: got %h want %h", pc_out, 32'h4); end
  endtask

  task automatic test_random;
    logic [31:0] m [32];
    logic [31:0] ins, exp_alu;
    logic [11:0] imm;
    logic        exp_we;
    int rd, rs1, rs2, kind;
    pulse_reset();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    for (int n = 0; n < 100; n++) begin
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 31); rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31);
      imm = 12'($urandom);
      if (kind < 4) begin
        ins = enc_add(rd, rs1, rs2); exp_alu = m[rs1] + m[rs2]; exp_we = (rd != 0);
      end else if (kind < 8) begin
        ins = enc_addi(rd, rs1, int'(imm)); exp_alu = m[rs1] + {{20{imm[11]}}, imm}; exp_we = (rd != 0);
      end else begin
        ins = {$urandom_range(0, 32'hFFFFF), 5'(rd), 7'b0110111}; exp_alu = 32'h0; exp_we = 1'b0;
      end
      drive(ins);
      if (kind < 8) begin
        tests++; if (alu_result !== exp_alu) begin fails++; $display("FAIL rand_alu[%0d]: got %h want %h", n, alu_result, exp_alu); end
      end
      tests++; if (rf_waddr !== 5'(rd)) begin fails++; $display("FAIL rand_waddr[%0d]: got %0d want %0d", n, rf_waddr, rd); end
      tests++; if (rf_we !== exp_we) begin fails++; $display("FAIL rand_we[%0d]: got %b want %b", n, rf_we, exp_we); end
      tick();
      if (exp_we) m[rd] = exp_alu;
    end
    tests++; if (pc_out !== 32'd400) begin fails++; $display("FAIL rand_pc: got %h want %h", pc_out, 32'd400); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add();
    test_branch_jump();
    test_x0();
    test_pc_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
